// File: rtl/noc_input_port_if.sv
// Handshake bundle between an upstream link, the input-port FIFO and the switch allocator.
// master drives flits and consumes the head; slave is the input port itself.
interface noc_input_port_if #(
    parameter int DATASIZE = 40
);
    logic                in_valid;
    logic [DATASIZE-1:0] in_data;
    logic                full;
    logic [3:0]          label;
    logic [DATASIZE-1:0] data_out;
    logic                ready;
    logic [15:0]         flit_cnt;

    modport master (
        output in_valid, in_data, ready,
        input  full, label, data_out, flit_cnt
    );

    modport slave (
        input  in_valid, in_data, ready,
        output full, label, data_out, flit_cnt
    );
endinterface

// File: rtl/noc_input_port.sv
// NoC router input port: flit FIFO plus XY route label for the head flit.
// Optional accepted-flit counter is built only with INPORT_FLIT_CNT_EN defined.
module noc_input_port #(
    parameter int DEPTH    = 8,
    parameter int DATASIZE = 40,
    parameter int CUR_X    = 0,
    parameter int CUR_Y    = 0
) (
    input logic             clk,
    input logic             rst_n,
    noc_input_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];
    localparam logic [1:0] CX = CUR_X[1:0];
    localparam logic [1:0] CY = CUR_Y[1:0];

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                full_w;
    logic                empty;
    logic                push;
    logic                pop;
    logic [DATASIZE-1:0] head;
    logic [1:0]          dst_x;
    logic [1:0]          dst_y;

    assign full_w = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign push   = bus.in_valid && !full_w;
    assign pop    = bus.ready && !empty;

    assign head  = mem[rd_ptr];
    assign dst_x = head[DATASIZE-5 -: 2];
    assign dst_y = head[DATASIZE-7 -: 2];

    assign bus.full     = full_w;
    assign bus.data_out = empty ? '0 : head;

    // Pointer and occupancy bookkeeping; push is already gated by full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flit storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // XY route request for the head flit, X dimension resolved first.
    always_comb begin
        bus.label = 4'b1111;
        if (!empty) begin
            unique case (1'b1)
                (dst_x > CX):                 bus.label = 4'b0010;
                (dst_x < CX):                 bus.label = 4'b1000;
                (dst_x == CX) && (dst_y > CY): bus.label = 4'b0001;
                (dst_x == CX) && (dst_y < CY): bus.label = 4'b0100;
                default:                      bus.label = 4'b0000;
            endcase
        end
    end

`ifdef INPORT_FLIT_CNT_EN
    logic [15:0] flit_cnt_q;

    // Saturating count of accepted flits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_cnt_q <= '0;
        end else if (push && (flit_cnt_q != 16'hFFFF)) begin
            flit_cnt_q <= flit_cnt_q + 1'b1;
        end
    end

    assign bus.flit_cnt = flit_cnt_q;
`else
    assign bus.flit_cnt = '0;
`endif
endmodule

// File: tb/tb_noc_input_port.sv
// Directed and random checks of noc_input_port against a queue model.
// Router sits at (1,1); the flit counter scenario depends on INPORT_FLIT_CNT_EN.
module tb_noc_input_port;
    localparam int DEPTH = 8;
    localparam int DW    = 40;

    logic clk = 1'b0;
    logic rst_n;

    noc_input_port_if #(.DATASIZE(DW)) bus ();

    noc_input_port #(
        .DEPTH(DEPTH), .DATASIZE(DW), .CUR_X(1), .CUR_Y(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    logic [15:0]   exp_cnt;
    int            vectors;
    int            errors;
    bit            last_push;

    function automatic logic [3:0] route(input logic [3:0] d);
        int dx;
        int dy;
        dx = int'(d[3:2]);
        dy = int'(d[1:0]);
        if (dx > 1) return 4'b0010;
        if (dx < 1) return 4'b1000;
        if (dy > 1) return 4'b0001;
        if (dy < 1) return 4'b0100;
        return 4'b0000;
    endfunction

    function automatic logic [DW-1:0] mk(input logic [3:0] dst);
        logic [7:0]  ts;
        logic [21:0] pl;
        logic [1:0]  ty;
        ts = 8'($urandom);
        pl = 22'($urandom);
        ty = 2'($urandom);
        return {4'h5, dst, ts, pl, ty};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0]    el;
        logic [DW-1:0] ed;
        el = 4'b1111;
        ed = '0;
        if (q.size() > 0) begin
            ed = q[0];
            el = route(ed[35:32]);
        end
        check({tag, ".full"}, 64'(bus.full), 64'(q.size() == DEPTH));
        check({tag, ".label"}, 64'(bus.label), 64'(el));
        check({tag, ".data"}, 64'(bus.data_out), 64'(ed));
        check({tag, ".cnt"}, 64'(bus.flit_cnt), 64'(exp_cnt));
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d,
                        input logic r, input bit chk, input string tag);
        bit push;
        bit pop;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.ready    = r;
        push = v && (q.size() < DEPTH);
        pop  = r && (q.size() > 0);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(d);
`ifdef INPORT_FLIT_CNT_EN
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
        end
        last_push = push;
        if (chk) check_outputs(tag);
    endtask

    initial begin
        logic [DW-1:0] f;
        logic [DW-1:0] held;
        logic [3:0]    dl[4];
        bit            v;

        vectors  = 0;
        errors   = 0;
        exp_cnt  = '0;
        last_push = 1'b0;
        rst_n    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        f = mk(4'b1001);
        step(1'b1, f, 1'b0, 1'b1, "east_push");
        check("east_label", 64'(bus.label), 64'(4'b0010));
        check("east_data", 64'(bus.data_out), 64'(f));
        step(1'b0, '0, 1'b1, 1'b1, "east_pop");
        check("east_idle", 64'(bus.label), 64'(4'b1111));

        dl[0] = 4'b0101;
        dl[1] = 4'b0100;
        dl[2] = 4'b0001;
        dl[3] = 4'b0110;
        foreach (dl[i]) begin
            step(1'b1, mk(dl[i]), 1'b0, 1'b1, "route_push");
            step(1'b0, '0, 1'b0, 1'b1, "route_hold");
            step(1'b0, '0, 1'b1, 1'b1, "route_pop");
        end

        for (int i = 0; i < DEPTH; i++)
            step(1'b1, mk(4'($urandom)), 1'b0, 1'b1, "fill");
        check("fill_full", 64'(bus.full), 64'(1));
        held = mk(4'b1110);
        step(1'b1, held, 1'b0, 1'b1, "held0");
        step(1'b1, held, 1'b0, 1'b1, "held1");
        step(1'b1, held, 1'b1, 1'b1, "pop_only");
        check("full_drop", 64'(bus.full), 64'(0));
        step(1'b1, held, 1'b0, 1'b1, "held_in");
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, '0, 1'b1, 1'b1, "drain");

        for (int i = 0; i < 4; i++)
            step(1'b1, mk(4'($urandom)), 1'b0, 1'b1, "prefill");
        for (int i = 0; i < 20; i++)
            step(1'b1, mk(4'($urandom)), 1'b1, 1'b1, "stream");
        check("stream_cnt", 64'(q.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            step(1'b0, '0, 1'b1, 1'b1, "stream_drain");

        for (int i = 0; i < 5; i++)
            step(1'b1, mk(4'($urandom)), 1'b0, 1'b1, "pre_rst");
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_cnt = '0;
        check_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        f = mk(4'b0010);
        bus.in_valid = 1'b1;
        bus.in_data  = f;
        bus.ready    = 1'b0;
        #1;
        check("no_bypass", 64'(bus.label), 64'(4'b1111));
        step(1'b1, f, 1'b0, 1'b1, "post_rst");
        check("post_rst_data", 64'(bus.data_out), 64'(f));
        step(1'b0, '0, 1'b1, 1'b1, "post_rst_pop");

        v = 1'b0;
        f = '0;
        last_push = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!v || last_push) begin
                v = ($urandom_range(0, 3) != 0);
                f = mk(4'($urandom));
            end
            step(v, f, ($urandom_range(0, 2) == 0), 1'b1, "random");
        end
        while (q.size() > 0)
            step(1'b0, '0, 1'b1, 1'b1, "rand_drain");

`ifdef INPORT_FLIT_CNT_EN
        while (exp_cnt < 16'hFFFC)
            step(1'b1, mk(4'($urandom)), 1'b1, 1'b0, "sat_run");
        check_outputs("sat_near");
        for (int i = 0; i < 5; i++)
            step(1'b1, mk(4'($urandom)), 1'b1, 1'b1, "sat");
        check("sat_cnt", 64'(bus.flit_cnt), 64'(16'hFFFF));
`else
        check("cnt_off", 64'(bus.flit_cnt), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
